vec_fwd_hazard_unit: RTL and testbench
======================================

Name: vec_fwd_hazard_unit

Overview:
- Parametrised successor to the vector pipeline's combinational forwarding logic.
- Keeps its own registered shadow of the destination tags in EX/MEM/WB and forwards for NUM_SRC source operands, with EX > MEM > WB > RF priority.
- Detects load-use hazards and drives the decode-stage stall, inserting bubbles. Counts stall cycles.
- Sits between the decode/operand-read stage and the EX input latch.

Parameters:
- DATA_W, 128, operand/result width (vector of 4x32 or scalar zero-extended).
- REG_AW, 4, register tag width; tag 0 is hardwired zero and never forwarded.
- NUM_SRC, 3, number of source operands per instruction.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  instruction in decode is valid.
- iss_we  in  1  issuing instruction writes a register.
- iss_load  in  1  issuing instruction is a memory load.
- iss_vf  in  1  issuing instruction targets the vector (1) or scalar (0) file.
- iss_dest  in  REG_AW  destination tag of the issuing instruction.
- src_use  in  NUM_SRC  per-source "operand is read" mask.
- src_vf  in  NUM_SRC  per-source register-file select.
- src_addr  in  NUM_SRC*REG_AW  packed source tags.
- src_rf_data  in  NUM_SRC*DATA_W  packed register-file read data.
- ex_res  in  DATA_W  EX-stage ALU result.
- mem_res  in  DATA_W  MEM-stage result (load data or passed ALU result).
- wb_res  in  DATA_W  WB-stage write data.
- flush  in  1  kill younger in-flight instructions (EX and MEM slots).
- hold  in  1  global pipeline freeze.
- src_data  out  NUM_SRC*DATA_W  forwarded operands.
- fwd_sel  out  NUM_SRC*2  per-source selected source (fwd_sel_e).
- stall  out  1  decode must hold; a bubble is injected into EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Slot state: three registered slots (EX, MEM, WB), each holding {valid, we, load, vf, dest}.
- Reset: all slots invalid, stall_cnt = 0. stall and fwd_sel are combinational from the slots, so after reset stall = 0, fwd_sel = SEL_RF and src_data = src_rf_data.
- Slot match for source i: use[i], addr != 0, slot.valid, slot.we, slot.dest == addr, slot.vf == src_vf[i].
- Operand select per source: EX match (non-load) -> ex_res; else MEM match -> mem_res; else WB match -> wb_res; else src_rf_data.
  - EX match on a load is never forwarded; it raises the hazard instead.
- Hazard: stall = iss_valid & ~hold & (any source matches an EX slot with load = 1).
  - Exactly one stall cycle per load-use; the next cycle forwards from MEM.
- Slot advance on each clock edge when ~hold:
  - WB <= MEM; MEM <= EX.
  - EX <= issuing instruction if iss_valid & ~stall; otherwise a bubble (valid = 0).
- hold = 1: all slots and stall_cnt frozen; stall forced to 0 (the freeze owner holds decode).
- flush = 1 (and ~hold): the next EX and MEM are invalid, WB <= old MEM; the issuing instruction is discarded. flush takes priority over issue and over stall.
  - flush with hold = 1: hold wins; the flush must be re-presented.
- stall_cnt increments on every cycle with stall = 1 and saturates at all-ones; no wrap.
- rst_n assertion mid-operation clears the slots immediately (asynchronously); outputs revert to RF pass-through in the same cycle.
- Width: src_data is a pure select, with no arithmetic and no truncation.

Decomposition:
- Package vec_fwd_pkg holds:
  - fwd_sel_e enum: SEL_RF = 0, SEL_WB = 1, SEL_MEM = 2, SEL_EX = 3.
  - pipe_slot_t struct {valid, we, load, vf, dest}.
  - Function tag_match(slot, addr, vf, use).
- One sub-module: vec_fwd_operand_sel (per-source priority select plus load-hit flag), instantiated NUM_SRC times with a generate loop.

Test Plan:
- Reset release with no issue -> stall = 0, fwd_sel = 0, src_data == src_rf_data for all sources; stall_cnt = 0.
- Issue ALU write vf = 1, dest = 5; next cycle source 0 reads vf = 1, r5, ex_res = 128'hA5.. -> src_data[0] = ex_res, fwd_sel[0] = SEL_EX. Same source with vf = 0 -> SEL_RF.
- Issue load dest = 3; next cycle source 1 reads r3 -> stall = 1 for exactly 1 cycle, stall_cnt = 1. Following cycle fwd_sel[1] = SEL_MEM, src_data[1] = mem_res, stall = 0.
- Writes to r7 in WB, MEM and EX simultaneously, source reads r7 -> SEL_EX chosen. Same test with r0 -> SEL_RF.
- flush while a load dest = 3 is in EX -> next cycle a read of r3 has no stall and takes SEL_RF. hold = 1 for 4 cycles -> slots and stall_cnt unchanged.
- Preload stall_cnt near max (force 16'hFFFE), then 3 stall cycles -> counter holds at 16'hFFFF. Assert rst_n = 0 mid-stall -> stall = 0 immediately.

Source files
------------

// File: rtl/vec_fwd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec_fwd_pkg : shared types and helpers for the vector forwarding unit  |
// | rev 1.0                                                                |
// +----------------------------------------------------------------------+
package vec_fwd_pkg;

   // Slot tags are stored at this fixed width; narrower REG_AW is zero-extended.
   localparam int unsigned C_TAG_W_MAX = 8;

   typedef enum logic [1:0] {
      SEL_RF  = 2'd0,
      SEL_WB  = 2'd1,
      SEL_MEM = 2'd2,
      SEL_EX  = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic                   valid;
      logic                   we;
      logic                   load;
      logic                   vf;
      logic [C_TAG_W_MAX-1:0] dest;
   } pipe_slot_t;

   localparam pipe_slot_t C_SLOT_EMPTY = '0;

   function automatic logic tag_match(
      input pipe_slot_t             slot,
      input logic [C_TAG_W_MAX-1:0] addr,
      input logic                   vf,
      input logic                   rd_en
   );
      return rd_en && (addr != '0) && slot.valid && slot.we &&
             (slot.dest == addr) && (slot.vf == vf);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vec_fwd_operand_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec_fwd_operand_sel : per-source EX > MEM > WB > RF select + load hit  |
// | rev 1.0                                                                |
// +----------------------------------------------------------------------+
module vec_fwd_operand_sel
   import vec_fwd_pkg::*;
#(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned REG_AW = 4
) (
   input  logic              i_rd_en,
   input  logic              i_vf,
   input  logic [REG_AW-1:0] i_addr,
   input  logic [DATA_W-1:0] i_rf_data,
   input  logic [DATA_W-1:0] i_ex_res,
   input  logic [DATA_W-1:0] i_mem_res,
   input  logic [DATA_W-1:0] i_wb_res,
   input  pipe_slot_t        i_ex_slot,
   input  pipe_slot_t        i_mem_slot,
   input  pipe_slot_t        i_wb_slot,
   output logic [DATA_W-1:0] o_data,
   output fwd_sel_e          o_sel,
   output logic              o_load_hit
);

   logic [C_TAG_W_MAX-1:0] w_addr;
   logic                   w_hit_ex;
   logic                   w_hit_mem;
   logic                   w_hit_wb;
   logic                   w_unused;

   always_comb begin
      w_addr             = '0;
      w_addr[REG_AW-1:0] = i_addr;
   end

   assign w_hit_ex   = tag_match(i_ex_slot,  w_addr, i_vf, i_rd_en);
   assign w_hit_mem  = tag_match(i_mem_slot, w_addr, i_vf, i_rd_en);
   assign w_hit_wb   = tag_match(i_wb_slot,  w_addr, i_vf, i_rd_en);
   assign o_load_hit = w_hit_ex & i_ex_slot.load;
   assign w_unused   = i_mem_slot.load ^ i_wb_slot.load;

   // A load in EX has no data yet, so it drops out and older stages are considered.
   always_comb begin
      o_sel  = SEL_RF;
      o_data = i_rf_data;
      if (w_hit_ex && !i_ex_slot.load) begin
         o_sel  = SEL_EX;
         o_data = i_ex_res;
      end else if (w_hit_mem) begin
         o_sel  = SEL_MEM;
         o_data = i_mem_res;
      end else if (w_hit_wb) begin
         o_sel  = SEL_WB;
         o_data = i_wb_res;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vec_fwd_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec_fwd_hazard_unit : slot shadow, operand forwarding, load-use stall  |
// | rev 1.0                                                                |
// +----------------------------------------------------------------------+
module vec_fwd_hazard_unit
   import vec_fwd_pkg::*;
#(
   parameter int unsigned DATA_W  = 128,
   parameter int unsigned REG_AW  = 4,
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_iss_valid,
   input  logic                        i_iss_we,
   input  logic                        i_iss_load,
   input  logic                        i_iss_vf,
   input  logic [REG_AW-1:0]           i_iss_dest,
   input  logic [NUM_SRC-1:0]          i_src_use,
   input  logic [NUM_SRC-1:0]          i_src_vf,
   input  logic [NUM_SRC*REG_AW-1:0]   i_src_addr,
   input  logic [NUM_SRC*DATA_W-1:0]   i_src_rf_data,
   input  logic [DATA_W-1:0]           i_ex_res,
   input  logic [DATA_W-1:0]           i_mem_res,
   input  logic [DATA_W-1:0]           i_wb_res,
   input  logic                        i_flush,
   input  logic                        i_hold,
   output logic [NUM_SRC*DATA_W-1:0]   o_src_data,
   output logic [NUM_SRC*2-1:0]        o_fwd_sel,
   output logic                        o_stall,
   output logic [CNT_W-1:0]            o_stall_cnt
);

   pipe_slot_t         r_ex;
   pipe_slot_t         r_mem;
   pipe_slot_t         r_wb;
   pipe_slot_t         w_issue;
   logic [NUM_SRC-1:0] w_load_hit;
   logic               w_stall;
   logic [CNT_W-1:0]   r_stall_cnt;

   always_comb begin
      w_issue                  = C_SLOT_EMPTY;
      w_issue.valid            = i_iss_valid;
      w_issue.we               = i_iss_we;
      w_issue.load             = i_iss_load;
      w_issue.vf               = i_iss_vf;
      w_issue.dest[REG_AW-1:0] = i_iss_dest;
   end

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         fwd_sel_e w_sel;

         vec_fwd_operand_sel #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
         ) u_sel (
            .i_rd_en    (i_src_use[gi]),
            .i_vf       (i_src_vf[gi]),
            .i_addr     (i_src_addr[gi*REG_AW +: REG_AW]),
            .i_rf_data  (i_src_rf_data[gi*DATA_W +: DATA_W]),
            .i_ex_res   (i_ex_res),
            .i_mem_res  (i_mem_res),
            .i_wb_res   (i_wb_res),
            .i_ex_slot  (r_ex),
            .i_mem_slot (r_mem),
            .i_wb_slot  (r_wb),
            .o_data     (o_src_data[gi*DATA_W +: DATA_W]),
            .o_sel      (w_sel),
            .o_load_hit (w_load_hit[gi])
         );

         assign o_fwd_sel[gi*2 +: 2] = w_sel;
      end
   endgenerate

   // Flush discards the issuing instruction, so there is nothing to stall for.
   assign w_stall = i_iss_valid & ~i_hold & ~i_flush & (|w_load_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex  <= C_SLOT_EMPTY;
         r_mem <= C_SLOT_EMPTY;
         r_wb  <= C_SLOT_EMPTY;
      end else if (!i_hold) begin
         r_wb <= r_mem;
         if (i_flush) begin
            r_mem <= C_SLOT_EMPTY;
            r_ex  <= C_SLOT_EMPTY;
         end else begin
            r_mem <= r_ex;
            r_ex  <= (i_iss_valid && !w_stall) ? w_issue : C_SLOT_EMPTY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign o_stall     = w_stall;
   assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vec_fwd_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vec_fwd_hazard_unit : directed + random check against a slot model  |
// | rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_vec_fwd_hazard_unit;
   import vec_fwd_pkg::*;

   localparam int DW = 128;
   localparam int AW = 4;
   localparam int NS = 3;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            iss_valid, iss_we, iss_load, iss_vf;
   logic [AW-1:0]   iss_dest;
   logic [NS-1:0]   src_use, src_vf;
   logic [NS*AW-1:0] src_addr;
   logic [NS*DW-1:0] src_rf_data;
   logic [DW-1:0]   ex_res, mem_res, wb_res;
   logic            flush, hold;
   logic [NS*DW-1:0] o_src_data;
   logic [NS*2-1:0] o_fwd_sel;
   logic            o_stall;
   logic [CW-1:0]   o_stall_cnt;

   always #5 clk = ~clk;

   vec_fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_iss_valid(iss_valid), .i_iss_we(iss_we), .i_iss_load(iss_load),
      .i_iss_vf(iss_vf), .i_iss_dest(iss_dest),
      .i_src_use(src_use), .i_src_vf(src_vf), .i_src_addr(src_addr),
      .i_src_rf_data(src_rf_data),
      .i_ex_res(ex_res), .i_mem_res(mem_res), .i_wb_res(wb_res),
      .i_flush(flush), .i_hold(hold),
      .o_src_data(o_src_data), .o_fwd_sel(o_fwd_sel),
      .o_stall(o_stall), .o_stall_cnt(o_stall_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
   bit m_v[3], m_we[3], m_ld[3], m_vf[3];
   int m_dst[3];
   int m_cnt = 0;
   bit m_stall;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_vf[k] = 0; m_dst[k] = 0;
      end
      m_cnt = 0;
   endtask

   task automatic idle();
      iss_valid = 0; iss_we = 0; iss_load = 0; iss_vf = 0; iss_dest = '0;
      src_use = '0; src_vf = '0; src_addr = '0; flush = 0; hold = 0;
      for (int i = 0; i < NS; i++) src_rf_data[i*DW +: DW] = rnd128();
      ex_res = rnd128(); mem_res = rnd128(); wb_res = rnd128();
   endtask

   task automatic set_iss(input bit v, input bit we, input bit ld, input bit vf, input int d);
      iss_valid = v; iss_we = we; iss_load = ld; iss_vf = vf; iss_dest = AW'(d);
   endtask

   task automatic set_src(input int i, input bit u, input bit vf, input int a);
      src_use[i] = u; src_vf[i] = vf; src_addr[i*AW +: AW] = AW'(a);
   endtask

   // Youngest matching producer wins; a load still in EX only raises the hazard.
   task automatic check_cycle();
      int          a, esel;
      bit          any_hit, hit;
      logic [DW-1:0] edata;
      @(negedge clk);
      any_hit = 0;
      for (int i = 0; i < NS; i++) begin
         a = int'(src_addr[i*AW +: AW]);
         esel = 0;
         edata = src_rf_data[i*DW +: DW];
         for (int k = 2; k >= 0; k--) begin
            hit = src_use[i] && a != 0 && m_v[k] && m_we[k] && m_dst[k] == a && m_vf[k] == src_vf[i];
            if (hit) begin
               if (k == 0 && m_ld[0]) any_hit = 1;
               else begin
                  esel = 3 - k;
                  edata = (k == 0) ? ex_res : (k == 1) ? mem_res : wb_res;
               end
            end
         end
         chk($sformatf("src%0d data", i), o_src_data[i*DW +: DW], edata);
         chk($sformatf("src%0d sel", i), DW'(o_fwd_sel[i*2 +: 2]), DW'(esel));
      end
      m_stall = iss_valid && !hold && !flush && any_hit;
      chk("stall", DW'(o_stall), DW'(m_stall));
      chk("stall_cnt", DW'(o_stall_cnt), DW'(m_cnt));
   endtask

   task automatic adv();
      if (!hold) begin
         m_v[2] = m_v[1]; m_we[2] = m_we[1]; m_ld[2] = m_ld[1]; m_vf[2] = m_vf[1]; m_dst[2] = m_dst[1];
         if (flush) begin
            m_v[1] = 0; m_v[0] = 0;
         end else begin
            m_v[1] = m_v[0]; m_we[1] = m_we[0]; m_ld[1] = m_ld[0]; m_vf[1] = m_vf[0]; m_dst[1] = m_dst[0];
            m_v[0] = iss_valid && !m_stall;
            m_we[0] = iss_we; m_ld[0] = iss_load; m_vf[0] = iss_vf; m_dst[0] = int'(iss_dest);
         end
         if (m_stall && m_cnt < CMAX) m_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_clear();
      idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // Reset state: pure RF pass-through
      idle(); check_cycle();
      chk("rst fwd_sel", DW'(o_fwd_sel), '0);
      adv();

      // EX forward, then vf mismatch falls back to RF
      idle(); set_iss(1, 1, 0, 1, 5); check_cycle(); adv();
      idle(); set_src(0, 1, 1, 5); ex_res = {4{32'hA5A5A5A5}}; check_cycle();
      chk("ex fwd sel", DW'(o_fwd_sel[1:0]), DW'(SEL_EX));
      chk("ex fwd data", o_src_data[DW-1:0], {4{32'hA5A5A5A5}});
      src_vf[0] = 0; #1;
      chk("vf mismatch sel", DW'(o_fwd_sel[1:0]), DW'(SEL_RF));
      adv();

      // Load-use: one stall, then MEM forward
      idle(); set_iss(1, 1, 1, 0, 3); check_cycle(); adv();
      idle(); set_iss(1, 1, 0, 0, 9); set_src(1, 1, 0, 3); check_cycle();
      chk("load-use stall", DW'(o_stall), 1);
      adv();
      check_cycle();
      chk("post-stall stall", DW'(o_stall), 0);
      chk("post-stall sel", DW'(o_fwd_sel[3:2]), DW'(SEL_MEM));
      chk("post-stall data", o_src_data[2*DW-1:DW], mem_res);
      chk("stall_cnt one", DW'(o_stall_cnt), 1);
      adv();

      // r7 in WB, MEM, EX at once; r0 never forwarded
      for (int n = 0; n < 3; n++) begin
         idle(); set_iss(1, 1, 0, 0, 7); check_cycle(); adv();
      end
      idle(); set_src(2, 1, 0, 7); check_cycle();
      chk("r7 priority", DW'(o_fwd_sel[5:4]), DW'(SEL_EX));
      src_addr[2*AW +: AW] = '0; #1;
      chk("r0 sel", DW'(o_fwd_sel[5:4]), DW'(SEL_RF));
      chk("r0 data", o_src_data[3*DW-1:2*DW], src_rf_data[3*DW-1:2*DW]);
      adv();

      // Flush kills a load in EX
      idle(); set_iss(1, 1, 1, 0, 3); check_cycle(); adv();
      idle(); flush = 1; set_iss(1, 1, 0, 0, 6); check_cycle(); adv();
      idle(); set_iss(1, 1, 0, 0, 8); set_src(0, 1, 0, 3); check_cycle();
      chk("flush no stall", DW'(o_stall), 0);
      chk("flush sel", DW'(o_fwd_sel[1:0]), DW'(SEL_RF));
      adv();

      // Hold freezes slots and counter, forces stall low
      idle(); set_iss(1, 1, 1, 0, 4); check_cycle(); adv();
      for (int n = 0; n < 4; n++) begin
         idle(); hold = 1; set_iss(1, 1, 0, 0, 8); set_src(0, 1, 0, 4); check_cycle();
         chk("hold stall", DW'(o_stall), 0);
         adv();
      end
      idle(); set_iss(1, 1, 0, 0, 8); set_src(0, 1, 0, 4); check_cycle();
      chk("after hold stall", DW'(o_stall), 1);
      adv();

      // Counter saturation
      for (int n = 0; n < 16; n++) begin
         idle(); set_iss(1, 1, 1, 1, 3); check_cycle(); adv();
         idle(); set_iss(1, 0, 0, 0, 0); set_src(1, 1, 1, 3); check_cycle(); adv();
      end
      idle(); check_cycle();
      chk("cnt saturated", DW'(o_stall_cnt), DW'(CMAX));
      adv();

      // Asynchronous reset in the middle of a stall
      idle(); set_iss(1, 1, 1, 0, 2); check_cycle(); adv();
      idle(); set_iss(1, 1, 0, 0, 5); set_src(0, 1, 0, 2); check_cycle();
      chk("pre-reset stall", DW'(o_stall), 1);
      #1 rst_n = 0;
      #1;
      chk("async rst stall", DW'(o_stall), 0);
      chk("async rst data", o_src_data[DW-1:0], src_rf_data[DW-1:0]);
      chk("async rst cnt", DW'(o_stall_cnt), 0);
      model_clear();
      @(posedge clk);
      #1 rst_n = 1;

      // Random traffic with dense tag reuse
      for (int n = 0; n < 2000; n++) begin
         idle();
         set_iss($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3));
         for (int i = 0; i < NS; i++)
            set_src(i, $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3));
         flush = ($urandom_range(0, 15) == 0);
         hold = ($urandom_range(0, 9) == 0);
         check_cycle();
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
